seq_detect_multi: RTL and testbench

SEQ_DETECT_MULTI -- requirements
Module: seq_detect_multi

---
 rtl/seq_detect_multi.sv | 94 +++++++++
 tb/tb_seq_detect_multi.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_multi.sv
// Multi-pattern serial sequence detector: shifts qualified bits into an N-bit
// window and compares it against P masked patterns, with overlap control.
module seq_detect_multi #(
  parameter int N  = 6,
  parameter int P  = 4,
  parameter int CW = 8,
  localparam int IW = (P > 1) ? $clog2(P) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            in_bit,
  input  logic            clear,
  input  logic            overlap,
  input  logic [P*N-1:0]  seq,
  input  logic [P*N-1:0]  mask,
  input  logic [P-1:0]    pat_en,
  output logic            match,
  output logic [P-1:0]    match_vec,
  output logic [IW-1:0]   match_id,
  output logic [CW-1:0]   match_count,
  output logic            primed
);

  localparam int FW = $clog2(N + 1);
  localparam logic [FW-1:0] FULL    = FW'(N);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  // Input handshake: there is no ready; a bit is consumed on every rising
  // edge where in_valid=1 and clear=0, and ignored otherwise.
  logic [N-1:0]  buffer;
  logic [FW-1:0] fill;

  logic [N-1:0]  buffer_next;
  logic [FW-1:0] fill_inc;
  logic [P-1:0]  hit;
  logic          any_hit;
  logic [IW-1:0] id_next;

  assign buffer_next = {buffer[N-2:0], in_bit};
  assign fill_inc    = (fill == FULL) ? FULL : fill + FW'(1);
  assign any_hit     = |hit;
  assign primed      = (fill == FULL);

  // Compare is against the window as it will look after this bit shifts in.
  always_comb begin
    hit = '0;
    for (int p = 0; p < P; p++) begin
      hit[p] = pat_en[p] && (fill_inc == FULL) &&
               (((buffer_next ^ seq[p*N +: N]) & mask[p*N +: N]) == '0);
    end
  end

  // Descending scan so the lowest set index wins.
  always_comb begin
    id_next = '0;
    for (int p = P - 1; p >= 0; p--) begin
      if (hit[p]) id_next = IW'(p);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buffer      <= '0;
      fill        <= '0;
      match       <= 1'b0;
      match_vec   <= '0;
      match_id    <= '0;
      match_count <= '0;
    end else if (clear) begin
      buffer      <= '0;
      fill        <= '0;
      match       <= 1'b0;
      match_vec   <= '0;
      match_id    <= '0;
      match_count <= '0;
    end else if (in_valid) begin
      buffer    <= buffer_next;
      // Non-overlapping mode restarts the fill so N fresh bits are required.
      fill      <= (any_hit && !overlap) ? '0 : fill_inc;
      match     <= any_hit;
      match_vec <= hit;
      match_id  <= id_next;
      if (any_hit && (match_count != CNT_MAX)) begin
        match_count <= match_count + CW'(1);
      end
    end else begin
      match     <= 1'b0;
      match_vec <= '0;
      match_id  <= '0;
    end
  end

endmodule

// File: tb/tb_seq_detect_multi.sv
// Directed bench for seq_detect_multi (N=6, P=2) plus a CW=2 instance for
// counter saturation; both instances share all inputs.
module tb_seq_detect_multi;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        clear = 1'b0;
  logic        overlap = 1'b1;
  logic [11:0] seq = 12'b000000_101101;
  logic [11:0] mask = 12'b000000_111111;
  logic [1:0]  pat_en = 2'b01;

  logic        match, s_match;
  logic [1:0]  match_vec, s_match_vec;
  logic        match_id, s_match_id;
  logic [7:0]  match_count;
  logic [1:0]  s_match_count;
  logic        primed, s_primed;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_detect_multi #(.N(6), .P(2), .CW(8)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .clear(clear), .overlap(overlap), .seq(seq), .mask(mask), .pat_en(pat_en),
    .match(match), .match_vec(match_vec), .match_id(match_id),
    .match_count(match_count), .primed(primed)
  );

  seq_detect_multi #(.N(6), .P(2), .CW(2)) u_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .clear(clear), .overlap(overlap), .seq(seq), .mask(mask), .pat_en(pat_en),
    .match(s_match), .match_vec(s_match_vec), .match_id(s_match_id),
    .match_count(s_match_count), .primed(s_primed)
  );

  // One clock edge with the given qualifier/bit; returns 1ns after the edge.
  task automatic step(input logic v, input logic b);
    in_valid = v;
    in_bit   = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    n_cmp++;
    if ({match, match_vec, match_id, match_count, primed} !== 13'd0) begin
      $display("FAIL reset_outputs got %b required 0", {match, match_vec, match_id, match_count, primed});
      n_err++;
    end
    reset = 1'b0;
  endtask

  task automatic test_priming();
    logic [5:0] s;
    s = 6'b101101;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, s[5-i]);
      if (i < 5) begin
        n_cmp++;
        if (match !== 1'b0 || primed !== 1'b0) begin
          $display("FAIL prime_early bit %0d match=%b primed=%b required 0/0", i, match, primed);
          n_err++;
        end
      end
    end
    n_cmp++;
    if (match !== 1'b1 || match_vec !== 2'b01 || match_id !== 1'b0 || match_count !== 8'd1 || primed !== 1'b1) begin
      $display("FAIL prime_match got m=%b v=%b id=%b c=%0d p=%b required 1/01/0/1/1", match, match_vec, match_id, match_count, primed);
      n_err++;
    end
    step(1'b0, 1'b0);
    n_cmp++;
    if (match !== 1'b0 || match_vec !== 2'b00 || primed !== 1'b1) begin
      $display("FAIL idle_after_match got m=%b v=%b p=%b required 0/00/1", match, match_vec, primed);
      n_err++;
    end
  endtask

  task automatic test_overlap();
    logic [8:0] s;
    logic exp_m;
    s = 9'b101101101;
    overlap = 1'b1;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, s[8-i]);
      exp_m = (i == 5 || i == 8);
      n_cmp++;
      if (match !== exp_m) begin
        $display("FAIL overlap1 bit %0d match=%b required %b", i, match, exp_m);
        n_err++;
      end
    end
    n_cmp++;
    if (match_count !== 8'd2) begin
      $display("FAIL overlap1_count got %0d required 2", match_count);
      n_err++;
    end
    overlap = 1'b0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, s[8-i]);
      exp_m = (i == 5);
      n_cmp++;
      if (match !== exp_m) begin
        $display("FAIL overlap0 bit %0d match=%b required %b", i, match, exp_m);
        n_err++;
      end
      if (i == 5) begin
        n_cmp++;
        if (primed !== 1'b0) begin
          $display("FAIL overlap0_primed got %b required 0", primed);
          n_err++;
        end
      end
    end
    n_cmp++;
    if (match_count !== 8'd1) begin
      $display("FAIL overlap0_count got %0d required 1", match_count);
      n_err++;
    end
    overlap = 1'b1;
  endtask

  task automatic test_gaps();
    logic [5:0] s;
    s = 6'b101101;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        for (int g = 0; g < 3; g++) begin
          step(1'b0, 1'b1);
          n_cmp++;
          if (match !== 1'b0) begin
            $display("FAIL gap cycle %0d match=%b required 0", g, match);
            n_err++;
          end
        end
      end
      step(1'b1, s[5-i]);
      n_cmp++;
      if (match !== (i == 5)) begin
        $display("FAIL gap_bit %0d match=%b required %b", i, match, (i == 5));
        n_err++;
      end
    end
    n_cmp++;
    if (match_count !== 8'd1) begin
      $display("FAIL gap_count got %0d required 1", match_count);
      n_err++;
    end
  endtask

  task automatic test_multi();
    logic [5:0] s;
    s = 6'b101101;
    seq    = 12'b000101_101101;
    mask   = 12'b000111_111111;
    pat_en = 2'b11;
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, s[5-i]);
    n_cmp++;
    if (match !== 1'b1 || match_vec !== 2'b11 || match_id !== 1'b0) begin
      $display("FAIL multi_both got m=%b v=%b id=%b required 1/11/0", match, match_vec, match_id);
      n_err++;
    end
    pat_en = 2'b10;
    step(1'b1, 1'b0);
    n_cmp++;
    if (match !== 1'b0 || match_vec !== 2'b00) begin
      $display("FAIL multi_miss got m=%b v=%b required 0/00", match, match_vec);
      n_err++;
    end
    step(1'b1, 1'b1);
    n_cmp++;
    if (match !== 1'b1 || match_vec !== 2'b10 || match_id !== 1'b1 || match_count !== 8'd2) begin
      $display("FAIL multi_p1 got m=%b v=%b id=%b c=%0d required 1/10/1/2", match, match_vec, match_id, match_count);
      n_err++;
    end
    seq    = 12'b000000_101101;
    mask   = 12'b000000_111111;
    pat_en = 2'b01;
  endtask

  task automatic test_sat_clear();
    logic [17:0] s;
    s = 18'b101101_101_101_101_101;
    do_reset();
    for (int i = 0; i < 18; i++) step(1'b1, s[17-i]);
    n_cmp++;
    if (s_match_count !== 2'd3 || match_count !== 8'd5) begin
      $display("FAIL sat_count got cw2=%0d cw8=%0d required 3/5", s_match_count, match_count);
      n_err++;
    end
    clear = 1'b1;
    step(1'b1, 1'b1);
    clear = 1'b0;
    n_cmp++;
    if (s_match_count !== 2'd0 || match_count !== 8'd0 || primed !== 1'b0 || s_primed !== 1'b0 || match !== 1'b0) begin
      $display("FAIL clear got c2=%0d c8=%0d p=%b m=%b required 0/0/0/0", s_match_count, match_count, primed, match);
      n_err++;
    end
    // Clear must not have consumed a bit: five more bits still leave it unprimed.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    n_cmp++;
    if (primed !== 1'b0) begin
      $display("FAIL clear_noshift primed=%b required 0", primed);
      n_err++;
    end
  endtask

  task automatic test_async_reset();
    logic [5:0] s;
    s = 6'b101101;
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, s[5-i]);
    n_cmp++;
    if (match !== 1'b1) begin
      $display("FAIL areset_pre match=%b required 1", match);
      n_err++;
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({match, match_vec, match_id, match_count, primed} !== 13'd0) begin
      $display("FAIL areset_async got %b required 0", {match, match_vec, match_id, match_count, primed});
      n_err++;
    end
    #1 reset = 1'b0;
    mask = 12'b000000_000000;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, s[5-i]);
      n_cmp++;
      if (match !== (i == 5)) begin
        $display("FAIL areset_refill bit %0d match=%b required %b", i, match, (i == 5));
        n_err++;
      end
    end
    mask = 12'b000000_111111;
  endtask

  initial begin
    test_reset();
    test_priming();
    test_overlap();
    test_gaps();
    test_multi();
    test_sat_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded bound");
    $fatal(1);
  end

endmodule
